core_sequencer: RTL and testbench

Single-clock instruction sequencer for the C0 core datapath. It fetches a 24-bit instruction word from instruction memory at the current PC address and decodes it into the core's control lines (MEM/ALU/JMP class, MS, IRS, RS, AR, BS, OP, IMM). It replaces the two free-running clocks with one-cycle strobes: REG_WE stands in for the CLK1 register/flag write and PC_STEP stands in for the CLK2 PC update. It sits between instruction memory and `core`, and gives the write and PC phases a guaranteed ordering.

---
 rtl/c0_seq_pkg.sv | 67 ++++++
 rtl/c0_inst_decode.sv | 55 +++++
 rtl/core_sequencer.sv | 133 +++++++++++++
 tb/tb_core_sequencer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c0_seq_pkg.sv
// Shared types and constants for the C0 core instruction sequencer.
// C0_SEQ_SINGLE_STEP_EN adds the PAUSE state used for single-step operation.
package c0_seq_pkg;

  localparam int unsigned IW_C    = 24;
  localparam int unsigned CLASS_W = 2;
  localparam int unsigned MS_W    = 2;
  localparam int unsigned OP_W    = 4;
  localparam int unsigned SEL_W   = 3;
  localparam int unsigned IMM_W   = 8;

  // Instruction field bit positions
  localparam int unsigned CLASS_HI = 23;
  localparam int unsigned CLASS_LO = 22;
  localparam int unsigned OP_HI    = 21;
  localparam int unsigned OP_LO    = 18;
  localparam int unsigned RS_HI    = 17;
  localparam int unsigned RS_LO    = 15;
  localparam int unsigned AR_HI    = 14;
  localparam int unsigned AR_LO    = 12;
  localparam int unsigned BS_HI    = 11;
  localparam int unsigned BS_LO    = 9;
  localparam int unsigned IRS_BIT  = 8;
  localparam int unsigned IMM_HI   = 7;
  localparam int unsigned IMM_LO   = 0;

  typedef enum logic [CLASS_W-1:0] {
    CLS_ALU  = 2'b00,
    CLS_MOVE = 2'b01,
    CLS_JMP  = 2'b10,
    CLS_SYS  = 2'b11
  } class_e;

  localparam logic [MS_W-1:0] MS_NONE = 2'b00;
  localparam logic [MS_W-1:0] MS_MEM  = 2'b11;

  localparam logic [OP_W-1:0] SYS_NOP  = 4'b0000;
  localparam logic [OP_W-1:0] SYS_HALT = 4'b0001;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_EXEC   = 3'd3,
    ST_COMMIT = 3'd4,
`ifdef C0_SEQ_SINGLE_STEP_EN
    ST_HALTED = 3'd5,
    ST_PAUSE  = 3'd6
`else
    ST_HALTED = 3'd5
`endif
  } state_e;

  typedef struct packed {
    logic             mem_inst;
    logic             alu_inst;
    logic             jmp_inst;
    logic [MS_W-1:0]  ms;
    logic             irs;
    logic [SEL_W-1:0] rs;
    logic [SEL_W-1:0] ar;
    logic [SEL_W-1:0] bs;
    logic [OP_W-1:0]  op;
    logic [IMM_W-1:0] imm;
  } ctrl_t;

endpackage

// File: rtl/c0_inst_decode.sv
// Combinational instruction decoder: IR -> control lines and execute flags.
module c0_inst_decode
  import c0_seq_pkg::*;
(
  input  logic [IW_C-1:0] ir,
  output ctrl_t           ctrl,
  output logic            is_halt,
  output logic            wr_reg,
  output logic            wr_flg
);

  class_e cls;

  always_comb begin
    ctrl    = '0;
    is_halt = 1'b0;
    wr_reg  = 1'b0;
    wr_flg  = 1'b0;
    cls     = class_e'(ir[CLASS_HI:CLASS_LO]);

    // Register/immediate fields pass through for every class
    ctrl.op  = ir[OP_HI:OP_LO];
    ctrl.rs  = ir[RS_HI:RS_LO];
    ctrl.ar  = ir[AR_HI:AR_LO];
    ctrl.bs  = ir[BS_HI:BS_LO];
    ctrl.irs = ir[IRS_BIT];
    ctrl.imm = ir[IMM_HI:IMM_LO];

    case (cls)
      CLS_ALU: begin
        ctrl.alu_inst = 1'b1;
        ctrl.ms       = MS_NONE;
        wr_reg        = 1'b1;
        wr_flg        = 1'b1;
      end
      CLS_MOVE: begin
        // MS=00 is an illegal move and degrades to a NOP
        ctrl.ms       = ctrl.op[MS_W-1:0];
        ctrl.mem_inst = (ctrl.op[MS_W-1:0] == MS_MEM);
        wr_reg        = (ctrl.op[MS_W-1:0] != MS_NONE);
      end
      CLS_JMP: begin
        ctrl.jmp_inst = 1'b1;
        ctrl.ms       = MS_NONE;
      end
      CLS_SYS: begin
        is_halt = (ctrl.op == SYS_HALT);
      end
      default: begin
        is_halt = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// Single-clock fetch/decode/execute/commit sequencer driving the C0 core strobes.
// Build option C0_SEQ_SINGLE_STEP_EN adds the STEP input and a PAUSE after COMMIT.
module core_sequencer
  import c0_seq_pkg::*;
#(
  parameter int unsigned IW = 24,
  parameter int unsigned AW = 8
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START,
  input  logic [AW-1:0] ADDR,
  output logic          IREQ,
  output logic [AW-1:0] IADDR,
  input  logic          IRDY,
  input  logic [IW-1:0] IDATA,
  output logic          MEM_INST,
  output logic          ALU_INST,
  output logic          JMP_INST,
  output logic [1:0]    MS,
  output logic          IRS,
  output logic [2:0]    RS,
  output logic [2:0]    AR,
  output logic [2:0]    BS,
  output logic [3:0]    OP,
  output logic [7:0]    IMM,
  output logic          REG_WE,
  output logic          FLG_WE,
  output logic          PC_STEP,
`ifdef C0_SEQ_SINGLE_STEP_EN
  input  logic          STEP,
`endif
  output logic          HALTED
);

  state_e        state, state_nxt;
  logic [IW-1:0] ir;
  logic [IW-1:0] dec_in;
  ctrl_t         dec_ctrl;
  ctrl_t         ctrl_q;
  logic          dec_halt, dec_wr_reg, dec_wr_flg;
  logic          ld_ir;
  logic          ireq_nxt, reg_we_nxt, flg_we_nxt, pc_step_nxt, halted_nxt;

  // Decode the incoming word during FETCH so control lines are valid in DECODE
  assign dec_in = (state == ST_FETCH) ? IDATA : ir;

  c0_inst_decode u_decode (
    .ir      (dec_in),
    .ctrl    (dec_ctrl),
    .is_halt (dec_halt),
    .wr_reg  (dec_wr_reg),
    .wr_flg  (dec_wr_flg)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    ld_ir       = 1'b0;
    ireq_nxt    = 1'b0;
    reg_we_nxt  = 1'b0;
    flg_we_nxt  = 1'b0;
    pc_step_nxt = 1'b0;
    halted_nxt  = 1'b0;

    case (state)
      ST_IDLE:   if (START) state_nxt = ST_FETCH;
      ST_FETCH: begin
        if (IRDY) begin
          state_nxt = ST_DECODE;
          ld_ir     = 1'b1;
        end
      end
      ST_DECODE: state_nxt = ST_EXEC;
      ST_EXEC:   state_nxt = dec_halt ? ST_HALTED : ST_COMMIT;
`ifdef C0_SEQ_SINGLE_STEP_EN
      ST_COMMIT: state_nxt = ST_PAUSE;
      ST_PAUSE:  if (STEP) state_nxt = ST_FETCH;
`else
      ST_COMMIT: state_nxt = ST_FETCH;
`endif
      ST_HALTED: if (START) state_nxt = ST_FETCH;
      default:   state_nxt = ST_IDLE;
    endcase

    // Strobes are registered from the state being entered, so they align with it
    ireq_nxt    = (state_nxt == ST_FETCH);
    reg_we_nxt  = (state_nxt == ST_EXEC) && dec_wr_reg;
    flg_we_nxt  = (state_nxt == ST_EXEC) && dec_wr_flg;
    pc_step_nxt = (state_nxt == ST_COMMIT);
    halted_nxt  = (state_nxt == ST_HALTED);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ir      <= '0;
      ctrl_q  <= '0;
      IREQ    <= 1'b0;
      REG_WE  <= 1'b0;
      FLG_WE  <= 1'b0;
      PC_STEP <= 1'b0;
      HALTED  <= 1'b0;
    end else begin
      IREQ    <= ireq_nxt;
      REG_WE  <= reg_we_nxt;
      FLG_WE  <= flg_we_nxt;
      PC_STEP <= pc_step_nxt;
      HALTED  <= halted_nxt;
      if (ld_ir) begin
        ir     <= IDATA;
        ctrl_q <= dec_ctrl;
      end
    end
  end

  // Fetch address tracks the live PC while the request is up
  assign IADDR    = IREQ ? ADDR : '0;
  assign MEM_INST = ctrl_q.mem_inst;
  assign ALU_INST = ctrl_q.alu_inst;
  assign JMP_INST = ctrl_q.jmp_inst;
  assign MS       = ctrl_q.ms;
  assign IRS      = ctrl_q.irs;
  assign RS       = ctrl_q.rs;
  assign AR       = ctrl_q.ar;
  assign BS       = ctrl_q.bs;
  assign OP       = ctrl_q.op;
  assign IMM      = ctrl_q.imm;

endmodule

// File: tb/tb_core_sequencer.sv
// Directed self-checking bench for core_sequencer.
module tb_core_sequencer;

  logic       CLK, RST, START, IRDY;
  logic [7:0] ADDR, IADDR;
  logic [23:0] IDATA;
  logic       IREQ, MEM_INST, ALU_INST, JMP_INST, IRS;
  logic [1:0] MS;
  logic [2:0] RS, AR, BS;
  logic [3:0] OP;
  logic [7:0] IMM;
  logic       REG_WE, FLG_WE, PC_STEP, HALTED;
`ifdef C0_SEQ_SINGLE_STEP_EN
  logic       STEP;
`endif

  int n_cmp = 0;
  int n_err = 0;

  wire [26:0] ctrl_o  = {MEM_INST, ALU_INST, JMP_INST, MS, IRS, RS, AR, BS, OP, IMM};
  wire [39:0] all_out = {IREQ, IADDR, ctrl_o, REG_WE, FLG_WE, PC_STEP, HALTED};

  core_sequencer #(.IW(24), .AW(8)) dut (
    .CLK(CLK), .RST(RST), .START(START), .ADDR(ADDR),
    .IREQ(IREQ), .IADDR(IADDR), .IRDY(IRDY), .IDATA(IDATA),
    .MEM_INST(MEM_INST), .ALU_INST(ALU_INST), .JMP_INST(JMP_INST),
    .MS(MS), .IRS(IRS), .RS(RS), .AR(AR), .BS(BS), .OP(OP), .IMM(IMM),
    .REG_WE(REG_WE), .FLG_WE(FLG_WE), .PC_STEP(PC_STEP),
`ifdef C0_SEQ_SINGLE_STEP_EN
    .STEP(STEP),
`endif
    .HALTED(HALTED)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [23:0] mk(input logic [1:0] c, input logic [3:0] op,
                                     input logic [2:0] rs, input logic [2:0] ar,
                                     input logic [2:0] bs, input logic irs,
                                     input logic [7:0] imm);
    return {c, op, rs, ar, bs, irs, imm};
  endfunction

  // COMMIT -> FETCH, passing through PAUSE when single-step is built in
  task automatic leave_commit;
    tick;
`ifdef C0_SEQ_SINGLE_STEP_EN
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (IREQ !== 1'b0) begin n_err++; $display("FAIL pause_hold ireq=%b exp 0", IREQ); end
      tick;
    end
    STEP = 1'b1;
    tick;
    STEP = 1'b0;
`endif
    n_cmp++;
    if (IREQ !== 1'b1) begin n_err++; $display("FAIL refetch ireq=%b exp 1", IREQ); end
  endtask

  task automatic test_reset;
    RST = 1'b1; START = 1'b0; IRDY = 1'b0; IDATA = '0; ADDR = '0;
`ifdef C0_SEQ_SINGLE_STEP_EN
    STEP = 1'b0;
`endif
    #2;
    n_cmp++;
    if (all_out !== 40'd0) begin n_err++; $display("FAIL reset_outputs got %h exp 0", all_out); end
    @(negedge CLK);
    RST = 1'b0;
    tick;
    n_cmp++;
    if (IREQ !== 1'b0) begin n_err++; $display("FAIL idle_no_start ireq=%b exp 0", IREQ); end
  endtask

  task automatic test_alu;
    ADDR = 8'h10; IDATA = mk(2'b00, 4'b0001, 3'd1, 3'd2, 3'd2, 1'b1, 8'h03);
    IRDY = 1'b1; START = 1'b1;
    tick;
    START = 1'b0;
    n_cmp++;
    if ({IREQ, IADDR} !== {1'b1, 8'h10}) begin
      n_err++; $display("FAIL alu_fetch ireq/iaddr=%b/%h exp 1/10", IREQ, IADDR);
    end
    tick;
    n_cmp++;
    if (ctrl_o !== {1'b0, 1'b1, 1'b0, 2'b00, 1'b1, 3'd1, 3'd2, 3'd2, 4'd1, 8'h03}) begin
      n_err++; $display("FAIL alu_decode ctrl=%h", ctrl_o);
    end
    n_cmp++;
    if ({IREQ, REG_WE, FLG_WE, PC_STEP} !== 4'b0000) begin
      n_err++; $display("FAIL alu_decode_strobes got %b exp 0000", {IREQ, REG_WE, FLG_WE, PC_STEP});
    end
    tick;
    n_cmp++;
    if ({REG_WE, FLG_WE, PC_STEP} !== 3'b110) begin
      n_err++; $display("FAIL alu_exec we/flg/pc=%b exp 110", {REG_WE, FLG_WE, PC_STEP});
    end
    tick;
    n_cmp++;
    if ({REG_WE, FLG_WE, PC_STEP} !== 3'b001) begin
      n_err++; $display("FAIL alu_commit we/flg/pc=%b exp 001", {REG_WE, FLG_WE, PC_STEP});
    end
    n_cmp++;
    if (IMM !== 8'h03 || ALU_INST !== 1'b1) begin
      n_err++; $display("FAIL alu_hold imm=%h alu=%b exp 03/1", IMM, ALU_INST);
    end
    leave_commit;
  endtask

  task automatic test_move_delay;
    int cyc, reg_cyc, flg_seen;
    ADDR = 8'h11; IDATA = mk(2'b01, 4'b0010, 3'd3, 3'd0, 3'd0, 1'b1, 8'h5A);
    cyc = 1; reg_cyc = 0; flg_seen = 0;
    while (PC_STEP !== 1'b1 && cyc < 20) begin
      IRDY = (cyc == 4);
      tick;
      cyc++;
      if (REG_WE === 1'b1) reg_cyc = cyc;
      if (FLG_WE === 1'b1) flg_seen = 1;
    end
    IRDY = 1'b0;
    n_cmp++;
    if (cyc != 7) begin n_err++; $display("FAIL move_latency cycles=%0d exp 7", cyc); end
    n_cmp++;
    if (reg_cyc != 6) begin n_err++; $display("FAIL move_reg_we cycle=%0d exp 6", reg_cyc); end
    n_cmp++;
    if (flg_seen != 0) begin n_err++; $display("FAIL move_flg_we seen=%0d exp 0", flg_seen); end
    n_cmp++;
    if (ctrl_o !== {1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 3'd3, 3'd0, 3'd0, 4'b0010, 8'h5A}) begin
      n_err++; $display("FAIL move_ctrl ctrl=%h", ctrl_o);
    end
    leave_commit;
  endtask

  task automatic test_jmp;
    ADDR = 8'h12; IDATA = mk(2'b10, 4'b1011, 3'd0, 3'd0, 3'd0, 1'b0, 8'h40);
    IRDY = 1'b1;
    tick;
    n_cmp++;
    if (ctrl_o !== {1'b0, 1'b0, 1'b1, 2'b00, 1'b0, 3'd0, 3'd0, 3'd0, 4'b1011, 8'h40}) begin
      n_err++; $display("FAIL jmp_ctrl ctrl=%h", ctrl_o);
    end
    tick;
    n_cmp++;
    if ({REG_WE, FLG_WE, PC_STEP} !== 3'b000) begin
      n_err++; $display("FAIL jmp_exec we/flg/pc=%b exp 000", {REG_WE, FLG_WE, PC_STEP});
    end
    tick;
    n_cmp++;
    if (PC_STEP !== 1'b1) begin n_err++; $display("FAIL jmp_commit pc_step=%b exp 1", PC_STEP); end
    leave_commit;
  endtask

  // MOVE to memory, illegal MOVE, SYS NOP variants
  task automatic test_move_variants;
    logic [23:0] word [3];
    logic [2:0]  exp_mem_ms [3];
    logic [1:0]  exp_we [3];
    word[0] = mk(2'b01, 4'b0011, 3'd5, 3'd1, 3'd0, 1'b0, 8'h77); exp_mem_ms[0] = 3'b111; exp_we[0] = 2'b10;
    word[1] = mk(2'b01, 4'b0100, 3'd2, 3'd0, 3'd0, 1'b0, 8'h00); exp_mem_ms[1] = 3'b000; exp_we[1] = 2'b00;
    word[2] = mk(2'b11, 4'b0010, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00); exp_mem_ms[2] = 3'b000; exp_we[2] = 2'b00;
    for (int i = 0; i < 3; i++) begin
      IDATA = word[i]; IRDY = 1'b1;
      tick;
      n_cmp++;
      if ({MEM_INST, MS} !== exp_mem_ms[i]) begin
        n_err++; $display("FAIL var%0d_mem_ms got %b exp %b", i, {MEM_INST, MS}, exp_mem_ms[i]);
      end
      tick;
      n_cmp++;
      if ({REG_WE, FLG_WE} !== exp_we[i]) begin
        n_err++; $display("FAIL var%0d_exec got %b exp %b", i, {REG_WE, FLG_WE}, exp_we[i]);
      end
      tick;
      n_cmp++;
      if ({PC_STEP, HALTED} !== 2'b10) begin
        n_err++; $display("FAIL var%0d_commit pc/halted=%b exp 10", i, {PC_STEP, HALTED});
      end
      leave_commit;
    end
  endtask

  task automatic test_halt;
    ADDR = 8'h22; IDATA = mk(2'b11, 4'b0001, 3'd0, 3'd0, 3'd0, 1'b0, 8'h00);
    IRDY = 1'b1;
    tick;
    tick;
    n_cmp++;
    if ({REG_WE, FLG_WE, PC_STEP, HALTED} !== 4'b0000) begin
      n_err++; $display("FAIL halt_exec got %b exp 0000", {REG_WE, FLG_WE, PC_STEP, HALTED});
    end
    for (int k = 0; k < 4; k++) begin
      tick;
      n_cmp++;
      if ({HALTED, PC_STEP, IREQ} !== 3'b100) begin
        n_err++; $display("FAIL halt_hold%0d halted/pc/ireq=%b exp 100", k, {HALTED, PC_STEP, IREQ});
      end
    end
    START = 1'b1;
    tick;
    START = 1'b0;
    IRDY = 1'b0;
    n_cmp++;
    if ({IREQ, IADDR, HALTED} !== {1'b1, 8'h22, 1'b0}) begin
      n_err++; $display("FAIL halt_restart ireq/iaddr/halted=%b/%h/%b exp 1/22/0", IREQ, IADDR, HALTED);
    end
  endtask

  task automatic test_reset_mid_fetch;
    ADDR = 8'h33;
    tick;
    n_cmp++;
    if (IREQ !== 1'b1) begin n_err++; $display("FAIL pre_reset_ireq got %b exp 1", IREQ); end
    #3;
    RST = 1'b1;
    #1;
    n_cmp++;
    if (all_out !== 40'd0) begin n_err++; $display("FAIL async_reset got %h exp 0", all_out); end
    tick;
    RST = 1'b0;
    tick;
    n_cmp++;
    if (IREQ !== 1'b0) begin n_err++; $display("FAIL no_retry ireq=%b exp 0", IREQ); end
    START = 1'b1;
    tick;
    START = 1'b0;
    n_cmp++;
    if ({IREQ, IADDR} !== {1'b1, 8'h33}) begin
      n_err++; $display("FAIL reset_refetch ireq/iaddr=%b/%h exp 1/33", IREQ, IADDR);
    end
  endtask

  initial begin
    test_reset;
    test_alu;
    test_move_delay;
    test_jmp;
    test_move_variants;
    test_halt;
    test_reset_mid_fetch;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
